// File: rtl/fp_div_pkg.sv
// Shared encodings for the single-precision divide back end.
`default_nettype none

package fp_div_pkg;

    localparam int XLEN     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int QW       = MAN_W + 3;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_NORM    = 3'd0,
        CLS_ZERO    = 3'd1,
        CLS_INF     = 3'd2,
        CLS_QNAN    = 3'd3,
        CLS_DIVZ    = 3'd4,
        CLS_INVALID = 3'd5
    } fp_class_e;

    // Bit positions inside the {NV, DZ, OF, UF, NX} flag vector.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

endpackage

`default_nettype wire

// File: rtl/fp_rne_incr.sv
// Round-to-nearest-even increment decision from the kept LSB, guard and sticky bits.
`default_nettype none

module fp_rne_incr
    import fp_div_pkg::*;
(
    input  logic lsb,
    input  logic guard,
    input  logic sticky,
    output logic inc
);

    // Above half rounds up; an exact half rounds up only when that makes the LSB even.
    assign inc = guard & (sticky | lsb);

endmodule

`default_nettype wire

// File: rtl/fp_div_round_pack.sv
// Post-divide normalise / RNE round / range check / IEEE-754 pack, two-stage valid/ready pipeline.
`default_nettype none

module fp_div_round_pack
    import fp_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W+1:0]   in_exp,
    input  logic [MAN_W+2:0]   in_quot,
    input  logic               in_rem_nz,
    input  logic [2:0]         in_class,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic [4:0]         flags
);

    // One extra bit over the 10-bit input so normalise and carry adjustments never wrap.
    localparam int XW = EXP_W + 3;
    localparam logic signed [XW-1:0] E_ONE  = XW'(1);
    localparam logic signed [XW-1:0] E_ZERO = '0;
    localparam logic signed [XW-1:0] E_MAX  = XW'(EXP_MAX);

    // ---------------- handshake ----------------
    logic s1_v;
    logic s1_load;
    logic s2_load;

    assign s2_load  = s1_v & (~out_valid | out_ready);
    assign in_ready = ~s1_v | ~out_valid | out_ready;
    assign s1_load  = in_valid & in_ready;

    // ---------------- stage 1: normalise ----------------
    logic signed [XW-1:0] exp_ext;
    logic signed [XW-1:0] n_e;
    logic [MAN_W-1:0]     n_frac;
    logic                 n_g;
    logic                 n_s;
    logic                 n_inc;

    assign exp_ext = $signed({in_exp[EXP_W+1], in_exp});

    // The leading one (bit 25 or bit 24) is implicit and never stored.
    always_comb begin
        n_e    = exp_ext;
        n_frac = in_quot[MAN_W+1:2];
        n_g    = in_quot[1];
        n_s    = in_quot[0] | in_rem_nz;
        if (!in_quot[MAN_W+2]) begin
            n_e    = exp_ext - E_ONE;
            n_frac = in_quot[MAN_W:1];
            n_g    = in_quot[0];
            n_s    = in_rem_nz;
        end
    end

    fp_rne_incr u_rne (
        .lsb    (n_frac[0]),
        .guard  (n_g),
        .sticky (n_s),
        .inc    (n_inc)
    );

    logic                 s1_sign;
    logic signed [XW-1:0] s1_e;
    logic [MAN_W-1:0]     s1_frac;
    logic                 s1_inc;
    logic                 s1_nx;
    fp_class_e            s1_class;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_sign  <= 1'b0;
            s1_e     <= '0;
            s1_frac  <= '0;
            s1_inc   <= 1'b0;
            s1_nx    <= 1'b0;
            s1_class <= CLS_NORM;
        end else begin
            if (s1_load) begin
                s1_v     <= 1'b1;
                s1_sign  <= in_sign;
                s1_e     <= n_e;
                s1_frac  <= n_frac;
                s1_inc   <= n_inc;
                s1_nx    <= n_g | n_s;
                s1_class <= fp_class_e'(in_class);
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end
        end
    end

    // ---------------- stage 2: round, range check, pack ----------------
    logic [MAN_W:0]       frac_sum;
    logic signed [XW-1:0] e_r;
    logic [XLEN-1:0]      res_c;
    logic [4:0]           flags_c;

    always_comb begin
        // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0 one binade up.
        frac_sum = {1'b0, s1_frac} + {{MAN_W{1'b0}}, s1_inc};
        e_r      = frac_sum[MAN_W] ? (s1_e + E_ONE) : s1_e;
        res_c    = '0;
        flags_c  = '0;
        case (s1_class)
            CLS_NORM: begin
                if (e_r >= E_MAX) begin
                    res_c            = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_c[FLAG_OF] = 1'b1;
                    flags_c[FLAG_NX] = 1'b1;
                end else if (e_r <= E_ZERO) begin
                    res_c            = {s1_sign, {(XLEN-1){1'b0}}};
                    flags_c[FLAG_UF] = 1'b1;
                    flags_c[FLAG_NX] = 1'b1;
                end else begin
                    res_c            = {s1_sign, e_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    flags_c[FLAG_NX] = s1_nx;
                end
            end
            CLS_ZERO: res_c = {s1_sign, {(XLEN-1){1'b0}}};
            CLS_INF:  res_c = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_DIVZ: begin
                res_c            = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_c[FLAG_DZ] = 1'b1;
            end
            CLS_INVALID: begin
                res_c            = XLEN'(CANON_NAN);
                flags_c[FLAG_NV] = 1'b1;
            end
            // Quiet NaN and the unused encodings all produce the canonical NaN.
            default: res_c = XLEN'(CANON_NAN);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                result    <= res_c;
                flags     <= flags_c;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_div_round_pack.sv
// Directed and randomized checks of fp_div_round_pack against a value-level rounding model.
`default_nettype none

module tb_fp_div_round_pack;
    import fp_div_pkg::*;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [25:0] q;
        logic        rz;
        logic [2:0]  c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [25:0] in_quot;
    logic        in_rem_nz;
    logic [2:0]  in_class;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    fp_div_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_quot   (in_quot),
        .in_rem_nz (in_rem_nz),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Reference: keep 24 bits of the quotient, compare the discarded part with one half.
    function automatic logic [36:0] model(input vec_t v);
        int          e;
        int          shift;
        longint      m;
        longint      rb;
        longint      half;
        logic        nx;
        logic [4:0]  f;
        logic [31:0] r;
        f = '0;
        r = '0;
        case (v.c)
            3'd1: r = {v.s, 31'b0};
            3'd2: r = {v.s, 8'hFF, 23'b0};
            3'd3: r = CANON_NAN;
            3'd4: begin r = {v.s, 8'hFF, 23'b0}; f[FLAG_DZ] = 1'b1; end
            3'd5: begin r = CANON_NAN; f[FLAG_NV] = 1'b1; end
            default: begin
                shift = v.q[25] ? 2 : 1;
                e     = int'($signed(v.e)) - (2 - shift);
                m     = longint'(v.q) >> shift;
                rb    = longint'(v.q) & ((longint'(1) << shift) - 1);
                half  = longint'(1) << (shift - 1);
                nx    = (rb != 0) || v.rz;
                if (rb > half || (rb == half && (v.rz || m[0]))) m = m + 1;
                if (m == (longint'(1) << 24)) begin
                    m = longint'(1) << 23;
                    e = e + 1;
                end
                if (e >= 255) begin
                    r = {v.s, 8'hFF, 23'b0};
                    f[FLAG_OF] = 1'b1;
                    f[FLAG_NX] = 1'b1;
                end else if (e <= 0) begin
                    r = {v.s, 31'b0};
                    f[FLAG_UF] = 1'b1;
                    f[FLAG_NX] = 1'b1;
                end else begin
                    r = {v.s, 8'(e), 23'(m)};
                    f[FLAG_NX] = nx;
                end
            end
        endcase
        return {f, r};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   ei;
        v.s  = 1'($urandom);
        v.q  = 26'($urandom);
        if (!v.q[25]) v.q[24] = 1'b1;
        if ($urandom_range(0, 3) == 0) v.q[1:0] = 2'($urandom_range(0, 3));
        v.rz = ($urandom_range(0, 2) == 0);
        v.c  = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 5));
        case ($urandom_range(0, 4))
            0:       ei = $urandom_range(0, 8) - 4;
            1:       ei = $urandom_range(250, 260);
            2:       ei = $urandom_range(0, 1023) - 512;
            default: ei = $urandom_range(1, 254);
        endcase
        v.e = 10'(ei);
        return v;
    endfunction

    task automatic present(input vec_t v);
        in_sign   = v.s;
        in_exp    = v.e;
        in_quot   = v.q;
        in_rem_nz = v.rz;
        in_class  = v.c;
        in_valid  = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input logic [36:0] expv, input bit rand_bp);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                tag_q.push_back(tag);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s_accept observed in_ready=0 for 200 cycles expected acceptance", tag);
        end
    endtask

    task automatic directed(input string tag, input vec_t v, input logic [31:0] er, input logic [4:0] ef);
        int n;
        present(v);
        wait_accept(tag, {ef, er}, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        checks++;
        assert (n === 2) else begin
            errors++;
            $error("FAIL %s_latency observed %0d expected 2", tag, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL %s_drain observed %0d outstanding expected 0", tag, exp_q.size());
        end
    endtask

    // Scoreboard: every transfer on the output side must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed %h expected no output", result);
            end
            if (exp_q.size() != 0) begin
                logic [36:0] ev;
                string       t;
                ev = exp_q.pop_front();
                t  = tag_q.pop_front();
                checks++;
                assert ({flags, result} === ev) else begin
                    errors++;
                    $error("FAIL %s observed result=%h flags=%b expected result=%h flags=%b",
                           t, result, flags, ev[31:0], ev[36:32]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed no completion expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        bp[4];
        logic [36:0] first_exp;
        vec_t        v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_quot   = '0;
        in_rem_nz = 1'b0;
        in_class  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({out_valid, result, flags} === 38'b0) else begin
            errors++;
            $error("FAIL reset_outputs observed valid=%b result=%h flags=%b expected 0/0/0",
                   out_valid, result, flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL reset_in_ready observed %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;

        // 6.0/2.0: eA - eB + 127 = 129 - 128 + 127 = 128, ratio 1.5
        directed("div6_2",    '{s:1'b0, e:10'd128, q:26'h3000000, rz:1'b0, c:3'd0}, 32'h40400000, 5'b00000);
        directed("ratio1_5",  '{s:1'b0, e:10'd127, q:26'h3000000, rz:1'b0, c:3'd0}, 32'h3FC00000, 5'b00000);
        directed("div1_3",    '{s:1'b0, e:10'd126, q:26'h1555555, rz:1'b1, c:3'd0}, 32'h3EAAAAAB, 5'b00001);
        directed("rnd_carry", '{s:1'b0, e:10'd127, q:26'h3FFFFFF, rz:1'b0, c:3'd0}, 32'h40000000, 5'b00001);
        directed("rne_tie",   '{s:1'b0, e:10'd127, q:26'h2000002, rz:1'b0, c:3'd0}, 32'h3F800000, 5'b00001);
        directed("overflow",  '{s:1'b0, e:10'd255, q:26'h2000000, rz:1'b0, c:3'd0}, 32'h7F800000, 5'b00101);
        directed("carry_ovf", '{s:1'b1, e:10'd254, q:26'h3FFFFFF, rz:1'b0, c:3'd0}, 32'hFF800000, 5'b00101);
        directed("underflow", '{s:1'b1, e:10'd0,   q:26'h2000000, rz:1'b0, c:3'd0}, 32'h80000000, 5'b00011);
        directed("norm_uf",   '{s:1'b0, e:10'd1,   q:26'h1000000, rz:1'b0, c:3'd0}, 32'h00000000, 5'b00011);
        directed("neg_exp",   '{s:1'b0, e:10'h3FD, q:26'h2000000, rz:1'b0, c:3'd0}, 32'h00000000, 5'b00011);
        directed("min_norm",  '{s:1'b0, e:10'd1,   q:26'h2000000, rz:1'b0, c:3'd0}, 32'h00800000, 5'b00000);
        directed("cls_zero",  '{s:1'b1, e:10'd300, q:26'h3FFFFFF, rz:1'b1, c:3'd1}, 32'h80000000, 5'b00000);
        directed("cls_inf",   '{s:1'b0, e:10'd5,   q:26'h1000000, rz:1'b1, c:3'd2}, 32'h7F800000, 5'b00000);
        directed("cls_qnan",  '{s:1'b1, e:10'd5,   q:26'h1000000, rz:1'b1, c:3'd3}, 32'h7FC00000, 5'b00000);
        directed("cls_divz",  '{s:1'b1, e:10'd0,   q:26'h2000000, rz:1'b0, c:3'd4}, 32'hFF800000, 5'b01000);
        directed("cls_inval", '{s:1'b0, e:10'd0,   q:26'h2000000, rz:1'b0, c:3'd5}, 32'h7FC00000, 5'b10000);

        // Back-pressure: two entries fill the pipe, the third must stall while output holds.
        for (int i = 0; i < 4; i++) begin
            bp[i]   = rand_vec();
            bp[i].c = 3'd0;
        end
        first_exp = model(bp[0]);
        out_ready = 1'b0;
        present(bp[0]);
        wait_accept("bp0", model(bp[0]), 1'b0);
        present(bp[1]);
        wait_accept("bp1", model(bp[1]), 1'b0);
        present(bp[2]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            assert ({in_ready, out_valid} === 2'b01) else begin
                errors++;
                $error("FAIL bp_stall observed in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
            end
            checks++;
            assert ({flags, result} === first_exp) else begin
                errors++;
                $error("FAIL bp_hold observed %h/%b expected %h/%b", result, flags, first_exp[31:0], first_exp[36:32]);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept("bp2", model(bp[2]), 1'b0);
        present(bp[3]);
        wait_accept("bp3", model(bp[3]), 1'b0);
        drain("bp");

        // Randomized stream with random output back-pressure and idle gaps.
        for (int i = 0; i < 300; i++) begin
            v = rand_vec();
            present(v);
            wait_accept("rand", model(v), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        drain("rand");

        // Reset mid-stream must discard everything in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            present(v);
            wait_accept("pre_rst", model(v), 1'b0);
        end
        present(rand_vec());
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tag_q.delete();
        #1;
        checks++;
        assert ({out_valid, in_ready} === 2'b01) else begin
            errors++;
            $error("FAIL rst_mid observed out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            assert (out_valid === 1'b0) else begin
                errors++;
                $error("FAIL rst_flush observed out_valid=%b expected 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        directed("post_rst", '{s:1'b1, e:10'd126, q:26'h1555555, rz:1'b1, c:3'd0}, 32'hBEAAAAAB, 5'b00001);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
